apb_req_master: RTL and testbench
=================================

APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; STRB_WIDTH = ceil(DATA_WIDTH/8).
REQ-003 SHALL have parameter TIMEOUT, default 0, max ACCESS cycles without PREADY; 0 = disabled.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 pclk_i  in  1  clock; all state on rising edge.
REQ-006 preset_i  in  1  asynchronous active-high reset.
REQ-007 req_valid_i/req_ready_o  in/out  1  request handshake.
REQ-008 req_addr_i  in  ADDR_WIDTH  target address; req_write_i  in  1  1=write.
REQ-009 req_wdata_i  in  DATA_WIDTH; req_strb_i  in  STRB_WIDTH; req_prot_i  in  3.
REQ-010 rsp_valid_o/rsp_ready_i  out/in  1  response handshake.
REQ-011 rsp_rdata_o  out  DATA_WIDTH; rsp_slverr_o  out  1; rsp_timeout_o  out  1.
REQ-012 paddr_o ADDR_WIDTH, pprot_o 3, psel_o 1, penable_o 1, pwrite_o 1, pwdata_o DATA_WIDTH, pstrb_o STRB_WIDTH: all out, APB master side.
REQ-013 pready_i 1, prdata_i DATA_WIDTH, pslverr_i 1: all in, from APB slave.

Function
REQ-014 SHALL implement FSM IDLE, SETUP, ACCESS, RESP.
REQ-015 req_ready_o SHALL be 1 only in IDLE, combinationally from state.
REQ-016 IDLE: on req_valid_i=1, register addr/write/wdata/strb/prot, go to SETUP next cycle.
REQ-017 SETUP: psel_o=1, penable_o=0 for exactly one cycle, then ACCESS.
REQ-018 ACCESS: psel_o=1, penable_o=1; stay while pready_i=0.
REQ-019 ACCESS with pready_i=1: capture prdata_i (reads; 0 for writes) and pslverr_i, rsp_timeout=0, go to RESP.
REQ-020 paddr/pprot/pwrite/pwdata/pstrb SHALL be driven from the registered request and stay stable from SETUP through last ACCESS cycle.
REQ-021 pwdata_o and pstrb_o SHALL be 0 on reads.
REQ-022 RESP: psel_o=0, penable_o=0, rsp_valid_o=1; rsp fields stable until rsp_ready_i=1, then IDLE.
REQ-023 Minimum latency: accept at cycle t, SETUP t+1, ACCESS t+2, rsp_valid_o at t+3 when pready_i=1 at t+2.
REQ-024 Minimum throughput: one transfer per 4 cycles; no new request accepted outside IDLE.
REQ-025 Timeout (TIMEOUT>0): counter of ACCESS cycles, cleared on SETUP entry; saturating, width clog2(TIMEOUT+1).
REQ-026 At the TIMEOUT-th ACCESS cycle with pready_i=0: leave ACCESS, go to RESP with rsp_slverr_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-027 pready_i=1 in the same cycle as timeout expiry SHALL win: normal completion, rsp_timeout_o=0.
REQ-028 TIMEOUT=0: ACCESS waits indefinitely; rsp_timeout_o constant 0.
REQ-029 prdata_i/pslverr_i SHALL be ignored outside ACCESS with pready_i=1.

Reset
REQ-030 preset_i=1 SHALL immediately force IDLE, psel_o=0, penable_o=0, rsp_valid_o=0, and all other registered outputs to 0.
REQ-031 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort the transfer with no response generated.
REQ-032 First request SHALL be accepted in the first cycle after preset_i deasserts.

Verification
REQ-033 Read, pready=1 at first ACCESS, prdata=0xDEADBEEF -> psel t+1..t+2, penable t+2, rsp_valid t+3, rdata 0xDEADBEEF, slverr 0.
REQ-034 Write addr 0x10 data 0x12345678 strb 0xF, pready low 3 ACCESS cycles -> pwrite/paddr/pwdata stable 5 cycles, rsp_valid at t+6, rdata 0.
REQ-035 pslverr_i=1 with pready_i=1 -> rsp_slverr_o=1, rsp_timeout_o=0.
REQ-036 TIMEOUT=4, pready never -> after 4 ACCESS cycles psel drops, rsp_slverr=1, rsp_timeout=1; repeat with pready=1 on 4th cycle -> normal completion.
REQ-037 rsp_ready_i held 0 for 5 cycles in RESP -> rsp stable, req_ready_o=0, req_valid_i ignored until handshake.
REQ-038 preset_i asserted during ACCESS -> psel/penable 0 same cycle, no rsp_valid, next request after release completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// Purpose : bridges a valid/ready request/response pair onto an APB master port (IDLE/SETUP/ACCESS/RESP).
// Latency : request accepted at cycle t, SETUP t+1, ACCESS t+2.., response valid the cycle after PREADY (min t+3).
// Backpr.  : one transfer in flight; req_ready_o only in IDLE, response held stable until rsp_ready_i.
//
// Ports:
//   pclk_i / preset_i                 clock, asynchronous active-high reset
//   req_*                             request channel (addr, write, wdata, strb, prot) with valid/ready
//   rsp_*                             response channel (rdata, slverr, timeout) with valid/ready
//   paddr_o .. pstrb_o, p*_i          APB master interface
module apb_req_master #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 0,
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    // request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    input  logic [2:0]            req_prot_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_slverr_o,
    output logic                  rsp_timeout_o,
    // APB master side
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // At least one bit so the counter exists even when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [2:0]            r_pprot;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_slverr;
    logic                  r_rsp_timeout;

    // r_cnt holds the number of ACCESS cycles already completed, so the
    // current cycle is the TIMEOUT-th one when r_cnt == TIMEOUT-1.
    logic w_expire;
    assign w_expire = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_paddr       <= '0;
            r_pprot       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_paddr  <= req_addr_i;
                        r_pprot  <= req_prot_i;
                        r_pwrite <= req_write_i;
                        // write data/strobes are zeroed on reads so the bus shows no stale data
                        r_pwdata <= req_write_i ? req_wdata_i : '0;
                        r_pstrb  <= req_write_i ? req_strb_i  : '0;
                        r_psel   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt != CNT_W'(TIMEOUT)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // pready wins over a timeout expiring in the same cycle
                    if (pready_i) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata_i;
                        r_rsp_slverr  <= pslverr_i;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= RESP;
                    end else if (w_expire) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_slverr_o  = r_rsp_slverr;
    assign rsp_timeout_o = r_rsp_timeout;
    assign paddr_o       = r_paddr;
    assign pprot_o       = r_pprot;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;

endmodule

// File: tb/tb_apb_req_master.sv
// Purpose : directed bench for apb_req_master with a response scoreboard.
// Latency : n/a (bench).
// Backpr.  : drives rsp_ready_i low for programmable hold periods.
module tb_apb_req_master;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    apb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk_i        (clk),
        .preset_i      (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_prot_i    (req_prot),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_slverr_o  (rsp_slverr),
        .rsp_timeout_o (rsp_timeout),
        .paddr_o       (paddr),
        .pprot_o       (pprot),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pready_i      (pready),
        .prdata_i      (prdata),
        .pslverr_i     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares every accepted response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata",   rsp_rdata,           e.rdata);
                chk("rsp_slverr",  {31'd0, rsp_slverr}, {31'd0, e.slverr});
                chk("rsp_timeout", {31'd0, rsp_timeout},{31'd0, e.timeout});
            end
        end
    end

    // delay = number of ACCESS cycles with pready low before pready rises;
    // delay >= TO means the slave never answers in time.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int delay, input bit err,
                        input logic [31:0] rdat, input int hold);
        bit   to;
        bit   done;
        int   k;
        rsp_t e;
        to        = (delay >= TO);
        e.rdata   = (wr || to) ? 32'd0 : rdat;
        e.slverr  = to ? 1'b1 : err;
        e.timeout = to;
        exp_q.push_back(e);

        @(posedge clk); #1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_strb = strb; req_prot = 3'd2;
        @(posedge clk); #1;
        // scramble request inputs: APB side must use the registered copy
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_strb = ~strb; req_write = ~wr;
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0BAD0;
        chk("setup_psel",    {31'd0, psel},    32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_paddr",   paddr, addr);
        chk("setup_pprot",   {29'd0, pprot}, 32'd2);
        chk("setup_pwdata",  pwdata, wr ? wdata : 32'd0);
        chk("setup_pstrb",   {28'd0, pstrb}, wr ? {28'd0, strb} : 32'd0);
        k = 0; done = 1'b0;
        while (!done && k < 50) begin
            @(posedge clk); #1;
            k++;
            chk("access_psel",    {31'd0, psel},    32'd1);
            chk("access_penable", {31'd0, penable}, 32'd1);
            chk("access_pwrite",  {31'd0, pwrite},  {31'd0, wr});
            chk("access_paddr",   paddr, addr);
            chk("access_pwdata",  pwdata, wr ? wdata : 32'd0);
            chk("rsp_valid_low",  {31'd0, rsp_valid}, 32'd0);
            pready  = (k == delay + 1);
            pslverr = pready ? err : 1'b1;
            prdata  = pready ? rdat : 32'hBAD0BAD0;
            if (pready || k == TO) done = 1'b1;
        end
        if (!done) chk("access_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        pready = 1'b0; pslverr = 1'b1; prdata = 32'h5A5A5A5A;
        chk("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_psel",      {31'd0, psel},      32'd0);
        chk("resp_penable",   {31'd0, penable},   32'd0);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0; req_valid = 1'b1;
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata",     rsp_rdata, e.rdata);
            @(posedge clk); #1;
            chk("hold_psel", {31'd0, psel}, 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel",      {31'd0, psel},      32'd0);
        chk("rst_penable",   {31'd0, penable},   32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_paddr",     paddr, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk); rst = 1'b0;

        //   wr  addr        wdata         strb   dly  err  rdata         hold
        xfer(0, 32'h100, 32'h0,        4'h0, 0,   0, 32'hDEADBEEF, 0);
        xfer(1, 32'h10,  32'h12345678, 4'hF, 3,   0, 32'h11111111, 0);
        xfer(0, 32'h20,  32'h0,        4'h0, 1,   1, 32'h00000055, 0);
        xfer(0, 32'h30,  32'h0,        4'h0, 100, 0, 32'h77777777, 0);
        xfer(1, 32'h40,  32'hA5A5A5A5, 4'h3, 100, 0, 32'h0,        1);
        xfer(0, 32'h44,  32'h0,        4'h0, 3,   0, 32'hCAFEF00D, 0);
        xfer(1, 32'h50,  32'h0BADF00D, 4'h5, 0,   0, 32'h0,        5);

        // Reset during ACCESS: transfer aborted, no response expected.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h60;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_access", {31'd0, penable}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_psel",      {31'd0, psel},      32'd0);
        chk("abort_penable",   {31'd0, penable},   32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_rsp_valid_held", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        xfer(0, 32'h64, 32'h0, 4'h0, 0, 0, 32'h01020304, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
